// File: rtl/audio_sample_fifo.sv
// First-word-fall-through sample FIFO between an I2S receiver and its consumer.
// Optional AUDIO_FIFO_DROP_CNT_EN adds a saturating 16-bit dropped-sample counter.
module audio_sample_fifo #(
   parameter int DATA_SIZE = 16,
   parameter int DEPTH     = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_SIZE-1:0]       in_data,
   input  logic                       in_valid,
   output logic [DATA_SIZE-1:0]       out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   input  logic                       clr_overflow
`ifdef AUDIO_FIFO_DROP_CNT_EN
   ,
   output logic [15:0]                drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic                 pop;
   logic                 push;
   logic                 drop;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr];

   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign pop  = out_valid && out_ready;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

`ifdef AUDIO_FIFO_DROP_CNT_EN
   // Clear and drop in one cycle restart the count at one.
   always_ff @(posedge clk) begin
      if (rst)
         drop_count <= '0;
      else if (clr_overflow)
         drop_count <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_count != '1)
         drop_count <= drop_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: reset, FWFT latency, fill/drain, overflow, wrap, mid-stream reset.
module tb_audio_sample_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        clr_overflow;
`ifdef AUDIO_FIFO_DROP_CNT_EN
   logic [15:0] drop_count;
`endif

   int checks = 0;
   int errors = 0;
   logic [15:0] model [$];

   always #5 clk = ~clk;

   audio_sample_fifo #(.DATA_SIZE(16), .DEPTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .count(count),
      .full(full),
      .empty(empty),
      .overflow(overflow),
      .clr_overflow(clr_overflow)
`ifdef AUDIO_FIFO_DROP_CNT_EN
      ,
      .drop_count(drop_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);

      // single sample, latency one
      in_valid = 1'b1; in_data = 16'hA5A5;
      tick();
      in_valid = 1'b0;
      chk("lat_out_valid", 32'(out_valid), 1);
      chk("lat_out_data", 32'(out_data), 32'h0000A5A5);
      chk("lat_count", 32'(count), 1);
      out_ready = 1'b1;
      tick();
      chk("pop1_empty", 32'(empty), 1);
      // out_ready while empty is ignored
      tick();
      chk("idle_pop_count", 32'(count), 0);
      out_ready = 1'b0;

      // fill 1..16
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1; in_data = 16'(i);
         model.push_back(16'(i));
         tick();
      end
      in_valid = 1'b0;
      chk("fill_full", 32'(full), 1);
      chk("fill_count", 32'(count), 16);
      chk("fill_head", 32'(out_data), 1);
      chk("fill_overflow", 32'(overflow), 0);

      // drop while full
      in_valid = 1'b1; in_data = 16'hBEEF;
      tick();
      in_valid = 1'b0;
      chk("drop_overflow", 32'(overflow), 1);
      chk("drop_count_entries", 32'(count), 16);
      chk("drop_head", 32'(out_data), 1);
`ifdef AUDIO_FIFO_DROP_CNT_EN
      chk("drop_cnt_1", 32'(drop_count), 1);
`endif

      // clear and drop together: set wins
      in_valid = 1'b1; in_data = 16'hDEAD; clr_overflow = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("clr_drop_overflow", 32'(overflow), 1);
`ifdef AUDIO_FIFO_DROP_CNT_EN
      chk("clr_drop_cnt", 32'(drop_count), 1);
`endif
      tick();
      clr_overflow = 1'b0;
      chk("clr_overflow", 32'(overflow), 0);
`ifdef AUDIO_FIFO_DROP_CNT_EN
      chk("clr_cnt", 32'(drop_count), 0);
`endif

      // push and pop together while full
      in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
      void'(model.pop_front());
      model.push_back(16'h1234);
      tick();
      in_valid = 1'b0;
      chk("pp_count", 32'(count), 16);
      chk("pp_overflow", 32'(overflow), 0);

      // drain, checking strict order
      for (int i = 0; i < 16; i++) begin
         chk("drain_valid", 32'(out_valid), 1);
         chk("drain_data", 32'(out_data), 32'(model.pop_front()));
         tick();
      end
      chk("drain_empty", 32'(empty), 1);
      chk("drain_count", 32'(count), 0);
      out_ready = 1'b0;

      // 40 pushes with out_ready toggling; pointers wrap
      for (int i = 0; i < 40; i++) begin
         logic p;
         in_valid = 1'b1; in_data = 16'h0100 + 16'(i); out_ready = i[0];
         p = (model.size() > 0) && out_ready;
         if (p) chk("wrap_data", 32'(out_data), 32'(model.pop_front()));
         if (model.size() < 16 || p) model.push_back(in_data);
         tick();
         chk("wrap_count", 32'(count), 32'(model.size()));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("wrap_tail", 32'(out_data), 32'(model.pop_front()));
         tick();
      end

      // reset mid-stream overrides push and pop
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_overflow", 32'(overflow), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, the sample width in bits (matches the receiver's audio_data).
REQ-002 SHALL have parameter DEPTH, default 16, the FIFO entry count; legal values are powers of two, at least 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in_data  input  DATA_SIZE  sample from the upstream I2S receiver.
REQ-007 in_valid  input  1  one-cycle strobe; in_data is valid while high (driven by the receiver's ready).
REQ-008 out_data  output  DATA_SIZE  head-of-FIFO sample.
REQ-009 out_valid  output  1  high when the FIFO is non-empty; out_data is then valid.
REQ-010 out_ready  input  1  consumer accept; a pop occurs when out_valid and out_ready are both high.
REQ-011 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 full / empty  output  1 each  count==DEPTH / count==0.
REQ-013 overflow  output  1  sticky flag: at least one sample was dropped.
REQ-014 clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-015 SHALL be first-word-fall-through: out_data = mem[rd_ptr] combinationally; out_valid = !empty.
REQ-016 Push condition: in_valid && (!full || pop in the same cycle).
REQ-017 A pushed sample SHALL appear at out_data with out_valid high on the cycle after the push edge when the FIFO was empty (latency 1).
REQ-018 Pop SHALL advance rd_ptr by 1; push writes mem[wr_ptr] and advances wr_ptr by 1; both pointers wrap modulo DEPTH.
REQ-019 count SHALL rise by 1 on push only, fall by 1 on pop only, and stay unchanged on a simultaneous push and pop.
REQ-020 A simultaneous push and pop while full SHALL accept the new sample, keeping count at DEPTH.
REQ-021 in_valid while full without a pop SHALL drop the new sample, keep the stored contents, and set overflow on the next edge.
REQ-022 A simultaneous push and pop while empty SHALL NOT be possible (out_valid is low), so it reduces to a push.
REQ-023 out_ready while empty SHALL be ignored; pointers and count are unchanged.
REQ-024 clr_overflow SHALL clear overflow on the next edge; if a drop occurs in the same cycle, overflow SHALL remain set (the set wins).
REQ-025 Stored ordering SHALL be strict FIFO order; samples are never reordered or duplicated.

Reset
REQ-026 When rst is high at an edge, the block SHALL set rd_ptr=0, wr_ptr=0, count=0, overflow=0; empty=1, full=0, out_valid=0.
REQ-027 Memory contents SHALL NOT require reset; out_data is don't-care while empty.
REQ-028 Reset mid-operation SHALL discard all stored samples and override any push or pop in the same cycle.

Configuration
REQ-029 Macro AUDIO_FIFO_DROP_CNT_EN defined: the block SHALL add output drop_count (16 bits), incremented on each dropped sample, saturating at 16'hFFFF, and cleared by rst or clr_overflow (an increment in the same cycle as the clear yields 1).
REQ-030 Macro undefined: drop_count port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 After reset, a single in_valid with in_data=16'hA5A5 -> next cycle out_valid=1, out_data=16'hA5A5, count=1.
REQ-032 Push 16 samples 0x0001..0x0010 with out_ready=0 -> full=1, count=16; then drain with out_ready=1 -> outputs 0x0001..0x0010 in order, then empty=1.
REQ-033 With the FIFO full, push 0xBEEF with no pop -> overflow=1, count=16, 0xBEEF never output; drop_count=1 when AUDIO_FIFO_DROP_CNT_EN is defined.
REQ-034 With the FIFO full, push 0x1234 and pop in the same cycle -> count stays 16, 0x1234 is the last sample out, overflow stays 0.
REQ-035 Apply clr_overflow and a drop in the same cycle -> overflow stays 1; clr_overflow alone on the next cycle -> overflow=0.
REQ-036 Push 40 samples with out_ready toggling every cycle (pointer wrap) -> output sequence equals the accepted input sequence; then assert rst mid-stream -> count=0 and out_valid=0 next cycle.
